button_reader: RTL

Input-side companion to the LED blinker: takes a raw, asynchronous, bouncing pushbutton line and turns it into a clean debounced level plus single-cycle press, release and long-press event pulses, and a wrapping press counter. Sits directly behind a board button pin and feeds control logic in the CLK domain. Like the blinker, all timing is derived from `CLOCK_FREQ`, so the block ports between boards without edits.

---
 rtl/button_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/button_reader.sv
// Debounced pushbutton front end: synchronizer, debounce FSM, press/release/long-press
// pulses and a wrapping press counter, all timed from CLOCK_FREQ.
module button_reader #(
    parameter int unsigned CLOCK_FREQ    = 100000000,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUTTON,
    output logic        PRESSED,
    output logic        PRESS,
    output logic        RELEASE,
    output logic        LONG_PRESS,
    output logic [15:0] PRESS_COUNT
);

    localparam logic [31:0] D_CYC  = 32'(CLOCK_FREQ / 32'd1000 * DEBOUNCE_MS);
    localparam logic [31:0] L_CYC  = 32'(CLOCK_FREQ / 32'd1000 * LONG_PRESS_MS);
    localparam logic [31:0] D_LAST = D_CYC - 32'd1;
    localparam logic [31:0] L_LAST = L_CYC - 32'd1;

    typedef enum logic [1:0] {
        UP,
        CHK_DOWN,
        DOWN,
        CHK_UP
    } state_t;

    logic        s1_q, s2_q;
    state_t      state_q, state_d;
    logic [31:0] dcnt_q, dcnt_d;
    logic [31:0] lcnt_q, lcnt_d;
    logic        pressed_q, pressed_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic [15:0] count_q, count_d;
    logic        go_down, go_up;

    // dcnt holds the number of new-level samples already seen, so the
    // D-th sample is the one that arrives while dcnt == D-1.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        go_down   = 1'b0;
        go_up     = 1'b0;
        case (state_q)
            UP: begin
                if (s2_q) begin
                    if (D_CYC == 32'd1) begin
                        go_down = 1'b1;
                    end else begin
                        state_d = CHK_DOWN;
                        dcnt_d  = 32'd1;
                    end
                end
            end
            CHK_DOWN: begin
                if (!s2_q) begin
                    state_d = UP;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    go_down = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 32'd1;
                end
            end
            DOWN: begin
                if (!s2_q) begin
                    if (D_CYC == 32'd1) begin
                        go_up = 1'b1;
                    end else begin
                        state_d = CHK_UP;
                        dcnt_d  = 32'd1;
                    end
                end
            end
            CHK_UP: begin
                if (s2_q) begin
                    state_d = DOWN;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    go_up = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 32'd1;
                end
            end
            default: begin
                state_d = UP;
                dcnt_d  = '0;
            end
        endcase
        if (go_down) begin
            state_d   = DOWN;
            dcnt_d    = '0;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            count_d   = count_q + 16'd1;
        end
        if (go_up) begin
            state_d   = UP;
            dcnt_d    = '0;
            pressed_d = 1'b0;
            release_d = 1'b1;
        end
    end

    // Hold timer runs across CHK_UP bounces; only a new accepted press restarts it.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (go_down) begin
            lcnt_d = '0;
        end else if (pressed_q && (lcnt_q != '1)) begin
            lcnt_d = lcnt_q + 32'd1;
            long_d = (lcnt_q == L_LAST);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= UP;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            s1_q      <= BUTTON;
            s2_q      <= s1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            count_q   <= count_d;
        end
    end

    assign PRESSED     = pressed_q;
    assign PRESS       = press_q;
    assign RELEASE     = release_q;
    assign LONG_PRESS  = long_q;
    assign PRESS_COUNT = count_q;

endmodule
